// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and sizing helper for the CNN datapath.
// Used by fc_score_layer and its fc_mac_lane multiply-accumulate lanes.
package cnn_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int FEAT_W      = 16;
    localparam int WW_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } fc_state_e;

    // Wide enough that N_IN full-scale products never overflow.
    function automatic int acc_width(input int n_in, input int ww);
        return FEAT_W + ww + $clog2(n_in);
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One signed MAC lane: accumulate, then shift/saturate/optional ReLU into a score.
// The FC_RELU_EN macro clamps negative scores to zero.
module fc_mac_lane
    import cnn_pkg::*;
#(
    parameter int WW    = WW_DEF,
    parameter int AW    = 32,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_load,
    input  logic signed [FEAT_W-1:0] i_data,
    input  logic signed [WW-1:0]     i_w,
    output logic        [FEAT_W-1:0] o_score
);

    localparam int PW = FEAT_W + WW;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    logic signed [PW-1:0]     w_prod;
    logic signed [AW-1:0]     w_sum;
    logic signed [AW-1:0]     w_shr;
    logic        [FEAT_W-1:0] w_sat;
    logic        [FEAT_W-1:0] w_score;
    logic signed [AW-1:0]     r_acc;
    logic        [FEAT_W-1:0] r_score;

    assign w_prod = i_data * i_w;
    assign w_sum  = r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};
    assign w_shr  = w_sum >>> SHIFT;

    // The score is taken from the sum including the final beat.
    always_comb begin
        w_sat = w_shr[FEAT_W-1:0];
        if (w_shr > SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_shr < SAT_MIN) begin
            w_sat = 16'h8000;
        end
`ifdef FC_RELU_EN
        w_score = w_sat[FEAT_W-1] ? '0 : w_sat;
`else
        w_score = w_sat;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_score <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= w_sum;
            end
            if (i_load) begin
                r_score <= w_score;
            end
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/fc_score_layer.sv
// Final FC layer: streams N_IN feature beats against four weight lanes, emits class scores.
// Define FC_RELU_EN to clamp scores to [0, 32767] for the unsigned classifier stage.
module fc_score_layer
    import cnn_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int WW    = WW_DEF,
    parameter int SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FEAT_W-1:0]         in_data,
    input  logic [NUM_CLASSES*WW-1:0] in_w,
    input  logic                      in_last,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [FEAT_W-1:0]         o_data_0,
    output logic [FEAT_W-1:0]         o_data_1,
    output logic [FEAT_W-1:0]         o_data_2,
    output logic [FEAT_W-1:0]         o_data_3,
    output logic                      o_frame_err
);

    localparam int AW = acc_width(N_IN, WW);
    localparam int CW = $clog2(N_IN + 1);

    fc_state_e       r_state;
    fc_state_e       w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_frame_err;
    logic            w_beat;
    logic            w_cnt_end;
    logic            w_last_beat;
    logic            w_clr;
    logic [FEAT_W-1:0] w_score [NUM_CLASSES];

    assign w_beat      = in_valid && in_ready;
    assign w_cnt_end   = (r_cnt == CW'(N_IN - 1));
    assign w_last_beat = w_beat && w_cnt_end;
    assign w_clr       = o_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_beat) w_next = ST_ACC;
            ST_ACC:  if (w_last_beat) w_next = ST_OUT;
            ST_OUT:  if (o_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state != ST_OUT);
        o_valid  = (r_state == ST_OUT);
    end

    // in_last is advisory only; the beat count decides where a frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_beat && (in_last != w_cnt_end);
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        fc_mac_lane #(
            .WW    (WW),
            .AW    (AW),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (w_clr),
            .i_en    (w_beat),
            .i_load  (w_last_beat),
            .i_data  (in_data),
            .i_w     (in_w[k*WW +: WW]),
            .o_score (w_score[k])
        );
    end

    assign o_data_0    = w_score[0];
    assign o_data_1    = w_score[1];
    assign o_data_2    = w_score[2];
    assign o_data_3    = w_score[3];
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_fc_score_layer.sv
// Testbench for fc_score_layer (N_IN=4): directed cases plus random frames
// checked against a dot-product / saturate / ReLU reference model.
module tb_fc_score_layer;

    localparam int NB = 4;
    localparam int WW = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [31:0] in_w;
    logic        in_last;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_data_0;
    logic [15:0] o_data_1;
    logic [15:0] o_data_2;
    logic [15:0] o_data_3;
    logic        o_frame_err;

    int n_chk;
    int n_fail;

    logic [15:0] f_data [NB];
    logic [31:0] f_w    [NB];
    logic        f_last [NB];
    logic [15:0] exp_s  [4];

    fc_score_layer #(
        .N_IN  (NB),
        .WW    (WW),
        .SHIFT (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_w        (in_w),
        .in_last     (in_last),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data_0    (o_data_0),
        .o_data_1    (o_data_1),
        .o_data_2    (o_data_2),
        .o_data_3    (o_data_3),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact dot product, then clamp, then optional ReLU.
    function automatic logic [15:0] ref_score(input int k);
        longint s;
        logic signed [15:0] d;
        logic signed [7:0]  w;
        logic [31:0] wv;
        s = 0;
        for (int b = 0; b < NB; b++) begin
            d  = f_data[b];
            wv = f_w[b];
            w  = wv[k*8 +: 8];
            s += longint'(d) * longint'(w);
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[15:0];
    endfunction

    task automatic chk_scores(input string tag);
        chk({tag, "_s0"}, {16'h0, o_data_0}, {16'h0, exp_s[0]});
        chk({tag, "_s1"}, {16'h0, o_data_1}, {16'h0, exp_s[1]});
        chk({tag, "_s2"}, {16'h0, o_data_2}, {16'h0, exp_s[2]});
        chk({tag, "_s3"}, {16'h0, o_data_3}, {16'h0, exp_s[3]});
    endtask

    task automatic drive_beat(input int b);
        in_valid = 1'b1;
        in_data  = f_data[b];
        in_w     = f_w[b];
        in_last  = f_last[b];
    endtask

    // Sends f_* as one frame, holds o_ready low for 'hold' cycles, then handshakes.
    task automatic do_frame(input string tag, input int hold);
        for (int k = 0; k < 4; k++) exp_s[k] = ref_score(k);
        o_ready = 1'b0;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            if (b == 0) begin
                chk({tag, "_err_pre"}, {31'h0, o_frame_err}, 32'h0);
            end else begin
                chk({tag, "_err"}, {31'h0, o_frame_err},
                    {31'h0, f_last[b-1] != (b - 1 == NB - 1)});
            end
            chk({tag, "_vld_acc"}, {31'h0, o_valid}, 32'h0);
            drive_beat(b);
        end
        @(negedge clk);
        chk({tag, "_err_last"}, {31'h0, o_frame_err},
            {31'h0, f_last[NB-1] != 1'b1});
        chk({tag, "_vld"}, {31'h0, o_valid}, 32'h1);
        chk({tag, "_rdy_out"}, {31'h0, in_ready}, 32'h0);
        chk_scores(tag);
        in_data = 16'($urandom);
        in_w    = $urandom;
        in_last = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, {31'h0, o_valid}, 32'h1);
            chk({tag, "_hold_rdy"}, {31'h0, in_ready}, 32'h0);
            chk({tag, "_hold_err"}, {31'h0, o_frame_err}, 32'h0);
            chk_scores({tag, "_hold"});
            in_data = 16'($urandom);
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_vld_post"}, {31'h0, o_valid}, 32'h0);
        chk({tag, "_rdy_post"}, {31'h0, in_ready}, 32'h1);
        chk_scores({tag, "_kept"});
        in_valid = 1'b0;
        o_ready  = 1'b0;
    endtask

    task automatic set_uniform(input logic [15:0] d, input logic [31:0] w);
        for (int b = 0; b < NB; b++) begin
            f_data[b] = d;
            f_w[b]    = w;
            f_last[b] = (b == NB - 1);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_w     = '0;
        in_last  = 1'b0;
        o_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'h0, in_ready}, 32'h1);
        chk("rst_vld", {31'h0, o_valid}, 32'h0);
        chk("rst_err", {31'h0, o_frame_err}, 32'h0);
        chk("rst_d0", {16'h0, o_data_0}, 32'h0);
        chk("rst_d3", {16'h0, o_data_3}, 32'h0);
        rst = 1'b0;

        // Features 1..4, lane k weight k+1 -> 10, 20, 30, 40.
        for (int b = 0; b < NB; b++) begin
            f_data[b] = 16'(b + 1);
            f_w[b]    = 32'h04030201;
            f_last[b] = (b == NB - 1);
        end
        do_frame("basic", 0);

        set_uniform(16'd32767, 32'h7F7F7F7F);
        do_frame("satpos", 0);

        set_uniform(16'd100, 32'h010101FF);
        do_frame("neg", 0);

        set_uniform(16'h8000, 32'h7F7F7F7F);
        do_frame("satneg", 0);

        set_uniform(16'd7, 32'h05FB0302);
        do_frame("stall", 5);

        for (int b = 0; b < NB; b++) begin
            f_data[b] = 16'(3 * b - 5);
            f_w[b]    = 32'hF0100AFE;
            f_last[b] = (b == 1);
        end
        do_frame("lasterr", 1);

        // Partial frame then reset; only the following clean frame may count.
        set_uniform(16'd1000, 32'h7F7F7F7F);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive_beat(b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_rst_vld", {31'h0, o_valid}, 32'h0);
        chk("mid_rst_rdy", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_d1", {16'h0, o_data_1}, 32'h0);
        chk("mid_rst_d2", {16'h0, o_data_2}, 32'h0);
        chk("mid_rst_err", {31'h0, o_frame_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_uniform(16'd9, 32'h01020304);
        do_frame("post_rst", 0);

        for (int n = 0; n < 30; n++) begin
            for (int b = 0; b < NB; b++) begin
                f_data[b] = 16'($urandom);
                f_w[b]    = $urandom;
                f_last[b] = (b == NB - 1);
                if ($urandom_range(0, 7) == 0) f_last[b] = ~f_last[b];
            end
            do_frame("rand", int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_score_layer.md
# fc_score_layer

Final fully-connected layer of the CNN datapath. It consumes a streamed feature vector and multiply-accumulates it against four per-class weight streams. Once per frame it presents four 16-bit class scores with a valid/ready handshake. It sits directly upstream of the 4-way max-select/classifier stage: its four score outputs drive that stage's four data inputs.

## Interface
- `N_IN`, 16: feature beats per frame (≥2).
- `WW`, 8: signed weight width per lane.
- `SHIFT`, 0: arithmetic right shift applied to each accumulator before saturation.
- `clk`  in  1: the single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: a feature beat is present.
- `in_ready`  out  1: the block can accept a beat.
- `in_data`  in  16: signed feature value.
- `in_w`  in  4*WW: signed weights; lane k occupies `[k*WW +: WW]`.
- `in_last`  in  1: the producer marks this beat as the final beat of the frame.
- `o_valid`  out  1: scores are valid.
- `o_ready`  in  1: the downstream stage accepts the scores.
- `o_data_0..o_data_3`  out  16 each: class scores for lanes 0..3.
- `o_frame_err`  out  1: single-cycle pulse when `in_last` disagrees with the beat count.

## Operation
- FSM states:
  - IDLE: accumulators are zero; waiting for the first beat.
  - ACC: accumulating a frame.
  - OUT: scores held for the downstream stage.
- A beat is accepted when `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACC, 0 in OUT.
- On each accepted beat, for every lane k: `acc_k <= acc_k + in_data * w_k`.
  - Products are signed 16×WW.
  - Accumulator width is 16+WW+clog2(N_IN), so the accumulator cannot overflow.
- Beat counter `cnt` increments on each accepted beat.
  - IDLE → ACC on the first beat.
  - The beat with `cnt == N_IN-1` ends the frame: state → OUT and the score registers load.
- Score per lane, in order:
  1. `s = acc_k >>> SHIFT`.
  2. Saturate `s` to [-32768, 32767].
  3. Apply the RELU_EN rule (see Configuration).
- `in_last` does not terminate a frame; the count is authoritative.
  - `o_frame_err` pulses for one cycle after any accepted beat where `in_last != (cnt == N_IN-1)`.
  - The frame continues normally after an error.
- OUT → IDLE on `o_valid && o_ready`. In the same cycle, the accumulators and `cnt` clear.
- Reset, including mid-frame, returns to IDLE. All accumulators and `cnt` clear, and any partial frame is discarded.

## Timing
- Reset values: `in_ready`=1, `o_valid`=0, `o_data_0..3`=0, `o_frame_err`=0, state IDLE.
- Latency: `o_valid` rises on the first edge after the last beat is accepted (1 cycle).
- In OUT, `o_valid` and `o_data_*` stay stable until the handshake completes. Beats presented during OUT are ignored (`in_ready`=0).
- `o_valid` falls the cycle after the handshake. `in_ready` returns to 1 in that same cycle.
- Minimum frame period is N_IN+1 cycles when `o_ready` is held high.
- `o_data_*` keep their last values after the handshake; only `o_valid` qualifies them.

## Configuration
- `FC_RELU_EN`:
  - Defined: each saturated score is clamped to 0 if negative, so outputs lie in [0, 32767]. This keeps the downstream unsigned comparison correct, and the macro must be defined when feeding the classifier.
  - Undefined: outputs are saturated two's-complement values, and negatives are passed through.

## Structure
- Shared package `cnn_pkg`:
  - `NUM_CLASSES`=4.
  - Feature width 16.
  - Default `WW`.
  - FSM state enum (IDLE/ACC/OUT).
  - Accumulator width function.
- Sub-module `fc_mac_lane`:
  - One signed multiply-accumulate lane with clear, enable, shift, saturate and optional ReLU.
  - Instantiated NUM_CLASSES times.
  - The parent owns the FSM, counter, handshake and error check.

## Test plan
- N_IN=4, SHIFT=0, features 1,2,3,4, lane-k weight k+1 on every beat, `o_ready`=1 → `o_valid` one cycle after beat 4 with scores 10, 20, 30, 40; `in_ready` returns to 1 the next cycle.
- Features 32767 ×4, all weights 127 → each lane sum 16645636 saturates; all scores 0x7FFF.
- Feature 100 ×4, lane-0 weight -1 → with FC_RELU_EN score 0; without it score 0xFE70 (-400).
- Full frame then `o_ready`=0 for 5 cycles while `in_valid`=1 → `o_valid`/`o_data_*` stable, `in_ready`=0, no beats absorbed; `o_ready`=1 → handshake, next frame's result is unaffected.
- N_IN=4 with `in_last` on beat 2 and not on beat 4 → `o_frame_err` pulses after beat 2 and after beat 4; scores are still correct after beat 4.
- Assert `rst` after 2 beats, release, send a clean frame → all outputs 0 during reset; the subsequent result equals the clean frame alone.
